voq_rr_scheduler: RTL
=====================

Name: voq_rr_scheduler

Overview:
- Egress-side stage directly downstream of a bank of NUM_VOQ virtual output queues.
- Mirrors each queue's occupancy from its write requests.
- Picks a non-empty queue round-robin and issues a one-cycle read request to it.
- Captures the returned buffer pointer and presents it to the egress datapath on a valid/ready handshake, one pointer in flight at a time.

Parameters:
- NUM_VOQ, 4, number of upstream queues (>=2).
- ADDR_W, 10, buffer pointer width.
- VOQ_DEPTH, 16, entries per queue (power of 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- voq_write_i  input  NUM_VOQ  copy of each queue's write request; used for occupancy tracking.
- voq_read_req_o  output  NUM_VOQ  one-hot read request, one bit per queue.
- voq_ptr_i  input  NUM_VOQ*ADDR_W  concatenated queue pointer outputs; queue k occupies bits [k*ADDR_W +: ADDR_W].
- voq_ptr_valid_i  input  NUM_VOQ  queue pointer-valid outputs.
- egress_ptr_o  output  ADDR_W  dequeued buffer pointer.
- egress_voq_o  output  $clog2(NUM_VOQ)  index of the source queue.
- egress_valid_o  output  1  pointer valid.
- egress_ready_i  input  1  egress accepts the pointer.
- voq_drop_o  output  NUM_VOQ  one-cycle pulse when a write hit a full queue (the queue discards it).
- err_o  output  1  sticky; set when a pointer-valid is missing.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0.
  - Occupancy counters 0, rr_ptr 0, state IDLE.
  - The queues are reset in the same cycle.
- Occupancy counter per queue, width $clog2(VOQ_DEPTH+1), updated every cycle:
  - write only: +1 if count<VOQ_DEPTH; else unchanged and voq_drop_o[k]=1 next cycle.
  - read_req_o[k] only: -1.
  - both in the same cycle: count==VOQ_DEPTH -> -1, write dropped, voq_drop_o[k]=1 next cycle; otherwise unchanged.
  - A read is never issued to a queue whose count is 0.
- Grant: the first k with count[k]!=0, searching rr_ptr, rr_ptr+1, ... mod NUM_VOQ.
- FSM states:
  - IDLE: if any count!=0, latch grant, set voq_read_req_o[grant]=1 (registered), go ISSUE; else stay.
  - ISSUE: read_req high for exactly this one cycle; the counter decrements this cycle. Go CAPTURE; read_req returns to 0.
  - CAPTURE:
    - if voq_ptr_valid_i[grant]=1: register egress_ptr_o from that queue's slice, egress_voq_o=grant, egress_valid_o=1; go HOLD.
    - else: set err_o, go IDLE; no egress output.
  - HOLD: egress_valid_o, egress_ptr_o and egress_voq_o stay stable until egress_ready_i=1. On the handshake edge: egress_valid_o=0, rr_ptr=(grant+1) mod NUM_VOQ, go IDLE.
- Latency: 3 cycles from the IDLE decision edge to egress_valid_o.
  - C0: IDLE, decision.
  - C1: read_req high.
  - C2: ptr_valid_i high.
  - C3: egress_valid_o high.
- Throughput: at most one pointer per 4 cycles when egress_ready_i is held high.
- Pointer-valid pulses on non-granted queues and outside CAPTURE are ignored.
- Writes are counted in every state, including HOLD.
- rr_ptr advances only on a successful handshake. It does not advance on the err_o path, so the same queue is retried first.
- Reset mid-operation (any state): an in-flight pointer is discarded and voq_read_req_o is forced to 0 the next cycle.

Test Plan:
- Single pointer: after reset, write 0x155 to VOQ2 -> voq_read_req_o=4'b0100 for exactly 1 cycle; egress_valid_o=1 with egress_ptr_o=0x155 and egress_voq_o=2 three cycles after the IDLE decision.
- Round-robin: 2 pointers each in VOQ0..3 (VOQ0: 0x010,0x011; VOQ1: 0x020,0x021; ...), ready held 1 -> egress order VOQ 0,1,2,3,0,1,2,3 with pointers 0x010,0x020,0x030,0x040,0x011,0x021,0x031,0x041; a new pointer every 4 cycles.
- Backpressure: egress_ready_i=0 for 10 cycles with VOQ1 holding 0x3FF -> egress_valid_o stays 1 and egress_ptr_o stays 0x3FF; no further read_req; handshake on cycle 11 -> next grant searched from VOQ2.
- Full/drop: 17 writes to VOQ3 with no reads (egress_ready_i=0, VOQ3 pointer parked in HOLD) -> voq_drop_o[3] pulses once; count[3] stays 16 until the handshake.
- Simultaneous write+read at full: count[0]=16, write in the ISSUE cycle for VOQ0 -> count 15, voq_drop_o[0]=1; write in ISSUE with count 5 -> count stays 5.
- Missing valid / reset: suppress voq_ptr_valid_i in CAPTURE -> err_o=1 sticky, egress_valid_o stays 0, same queue re-granted. Assert rst during HOLD -> next cycle all outputs 0, counts 0.

Source files
------------

// File: rtl/voq_rr_scheduler.sv
// Round-robin dequeue scheduler for a bank of virtual output queues.
// Tracks per-queue occupancy from the write strobes, issues one-cycle read
// requests to a non-empty queue and hands the returned buffer pointer to the
// egress datapath over a valid/ready handshake, one pointer at a time.
module voq_rr_scheduler #(
    parameter int unsigned NUM_VOQ   = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned VOQ_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_VOQ-1:0]         voq_write_i,
    output logic [NUM_VOQ-1:0]         voq_read_req_o,
    input  logic [NUM_VOQ*ADDR_W-1:0]  voq_ptr_i,
    input  logic [NUM_VOQ-1:0]         voq_ptr_valid_i,
    output logic [ADDR_W-1:0]          egress_ptr_o,
    output logic [$clog2(NUM_VOQ)-1:0] egress_voq_o,
    output logic                       egress_valid_o,
    input  logic                       egress_ready_i,
    output logic [NUM_VOQ-1:0]         voq_drop_o,
    output logic                       err_o
);

    localparam int unsigned IdxW = $clog2(NUM_VOQ);
    localparam int unsigned CntW = $clog2(VOQ_DEPTH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(VOQ_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture,
        StHold
    } state_e;

    state_e              state_q;
    logic [IdxW-1:0]     rr_ptr_q;
    logic [IdxW-1:0]     grant_q;
    logic [NUM_VOQ-1:0]  read_req_q;
    logic [ADDR_W-1:0]   egress_ptr_q;
    logic [IdxW-1:0]     egress_voq_q;
    logic                egress_valid_q;
    logic                err_q;

    logic [CntW-1:0]     count_q [NUM_VOQ];
    logic [CntW-1:0]     count_d [NUM_VOQ];
    logic [NUM_VOQ-1:0]  drop_q;
    logic [NUM_VOQ-1:0]  drop_d;

    logic [NUM_VOQ-1:0]  nonempty;
    logic                grant_found;
    logic [IdxW-1:0]     grant_idx;
    logic [NUM_VOQ-1:0]  grant_oh;
    logic [ADDR_W-1:0]   ptr_sel;
    logic                ptr_sel_valid;
    logic [IdxW-1:0]     rr_next;

    // Occupancy next-state: a write at full is discarded by the queue, so it is
    // dropped here too, even when a read frees a slot in the same cycle.
    always_comb begin
        for (int k = 0; k < NUM_VOQ; k++) begin
            count_d[k] = count_q[k];
            drop_d[k]  = 1'b0;
            case ({voq_write_i[k], read_req_q[k]})
                2'b10: begin
                    if (count_q[k] < CntMax) begin
                        count_d[k] = count_q[k] + 1'b1;
                    end else begin
                        drop_d[k] = 1'b1;
                    end
                end
                2'b01: count_d[k] = count_q[k] - 1'b1;
                2'b11: begin
                    if (count_q[k] == CntMax) begin
                        count_d[k] = count_q[k] - 1'b1;
                        drop_d[k]  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Occupancy counters and drop pulses, updated in every FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_VOQ; k++) begin
                count_q[k] <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int k = 0; k < NUM_VOQ; k++) begin
                count_q[k] <= count_d[k];
            end
            drop_q <= drop_d;
        end
    end

    // Non-empty flags per queue.
    always_comb begin
        for (int k = 0; k < NUM_VOQ; k++) begin
            nonempty[k] = (count_q[k] != '0);
        end
    end

    // Round-robin search: first non-empty queue starting at rr_ptr_q.
    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_VOQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_VOQ;
            if (!grant_found && nonempty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'(cand);
            end
        end
        grant_oh            = '0;
        grant_oh[grant_idx] = 1'b1;
    end

    // Pointer slice and valid of the granted queue; rr pointer after it.
    always_comb begin
        ptr_sel       = voq_ptr_i[32'(grant_q) * ADDR_W +: ADDR_W];
        ptr_sel_valid = voq_ptr_valid_i[grant_q];
        rr_next       = (32'(grant_q) == NUM_VOQ - 1) ? '0 : grant_q + 1'b1;
    end

    // Dequeue FSM with registered read request and egress outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            read_req_q     <= '0;
            egress_ptr_q   <= '0;
            egress_voq_q   <= '0;
            egress_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        grant_q    <= grant_idx;
                        read_req_q <= grant_oh;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    read_req_q <= '0;
                    state_q    <= StCapture;
                end
                StCapture: begin
                    if (ptr_sel_valid) begin
                        egress_ptr_q   <= ptr_sel;
                        egress_voq_q   <= grant_q;
                        egress_valid_q <= 1'b1;
                        state_q        <= StHold;
                    end else begin
                        // rr_ptr_q is left alone so this queue is retried first.
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StHold: begin
                    if (egress_ready_i) begin
                        egress_valid_q <= 1'b0;
                        rr_ptr_q       <= rr_next;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign voq_read_req_o = read_req_q;
    assign egress_ptr_o   = egress_ptr_q;
    assign egress_voq_o   = egress_voq_q;
    assign egress_valid_o = egress_valid_q;
    assign voq_drop_o     = drop_q;
    assign err_o          = err_q;

endmodule
